// File: rtl/tpu_skew_feeder.sv
// rtl/tpu_skew_feeder.sv - operand tile buffer that streams a diagonally skewed tile into a systolic array
module tpu_skew_feeder #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   WrEn,
  input  logic [$clog2(DIM)-1:0] Waddr,
  input  logic [DIM*BITS_AB-1:0] Wdata,
  input  logic                   start,
  output logic [DIM*BITS_AB-1:0] Aout,
  output logic                   mac_en,
  output logic                   busy,
  output logic                   done
);

  localparam int AW     = $clog2(DIM);
  // Last step index: 2*DIM-1 skewed beats plus DIM-1 drain beats for the far corner.
  localparam int LAST_K = 3 * DIM - 3;
  localparam int KW     = $clog2(LAST_K + 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [BITS_AB-1:0]     mem_q [DIM][DIM];
  logic [BITS_AB-1:0]     mem_d [DIM][DIM];
  logic [DIM*BITS_AB-1:0] aout_q, aout_d;
  logic                   mac_en_q, mac_en_d;
  logic                   done_q, done_d;
  logic                   load;

  // Next-state, tile writes and the skewed lane selection for the k being loaded
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    mem_d    = mem_q;
    aout_d   = '0;
    mac_en_d = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        // A write in the same cycle as start takes priority and drops the start.
        if (WrEn) begin
          if (int'(Waddr) < DIM) begin
            for (int c = 0; c < DIM; c++) begin
              mem_d[Waddr][c] = Wdata[c*BITS_AB +: BITS_AB];
            end
          end
        end else if (start) begin
          state_d  = STREAM;
          k_d      = '0;
          mac_en_d = 1'b1;
          load     = 1'b1;
        end
      end
      STREAM: begin
        if (k_q == KW'(LAST_K)) begin
          state_d = IDLE;
          k_d     = '0;
          done_d  = 1'b1;
        end else begin
          k_d      = k_q + KW'(1);
          mac_en_d = 1'b1;
          load     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Lane i lags by i beats: it carries column k-i of row i while that column exists.
    if (load) begin
      for (int i = 0; i < DIM; i++) begin
        int diag;
        diag = int'(k_d) - i;
        if (diag >= 0 && diag < DIM) begin
          aout_d[i*BITS_AB +: BITS_AB] = mem_q[AW'(i)][AW'(diag)];
        end
      end
    end
  end

  // State, step counter, tile storage and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      aout_q   <= '0;
      mac_en_q <= 1'b0;
      done_q   <= 1'b0;
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      aout_q   <= aout_d;
      mac_en_q <= mac_en_d;
      done_q   <= done_d;
      mem_q    <= mem_d;
    end
  end

  assign Aout   = aout_q;
  assign mac_en = mac_en_q;
  assign busy   = mac_en_q;
  assign done   = done_q;

endmodule

// File: tb/tb_tpu_skew_feeder.sv
// tb/tb_tpu_skew_feeder.sv - directed self-checking bench for tpu_skew_feeder
module tb_tpu_skew_feeder;

  localparam int BITS_AB  = 8;
  localparam int DIM      = 4;
  localparam int AW       = 2;
  localparam int W        = DIM * BITS_AB;
  localparam int PASS_LEN = 3 * DIM - 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          WrEn = 1'b0;
  logic [AW-1:0] Waddr = '0;
  logic [W-1:0]  Wdata = '0;
  logic          start = 1'b0;
  logic [W-1:0]  Aout;
  logic          mac_en;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BITS_AB-1:0] tmem [DIM][DIM];
  logic [W-1:0]       cap  [PASS_LEN];

  tpu_skew_feeder #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .WrEn(WrEn), .Waddr(Waddr), .Wdata(Wdata),
    .start(start), .Aout(Aout), .mac_en(mac_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_aout(input int k);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < DIM; i++) begin
      if (k - i >= 0 && k - i < DIM) v[i*BITS_AB +: BITS_AB] = tmem[i][k-i];
    end
    return v;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) tmem[r][c] = '0;
  endtask

  task automatic write_row(input int r, input logic [W-1:0] d);
    WrEn = 1'b1; Waddr = AW'(r); Wdata = d;
    @(negedge clk);
    WrEn = 1'b0; Wdata = '0;
    for (int c = 0; c < DIM; c++) tmem[r][c] = d[c*BITS_AB +: BITS_AB];
  endtask

  // Runs one pass from IDLE; optional illegal write (wr_k) and start (st_k) mid-pass.
  task automatic run_pass(input string nm, input int wr_k, input int st_k, input bit b2b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < PASS_LEN; k++) begin
      cap[k] = Aout;
      n_checks++;
      if (Aout !== exp_aout(k)) begin
        n_fail++;
        $display("FAIL %s aout k=%0d: got %h want %h", nm, k, Aout, exp_aout(k));
      end
      n_checks++;
      if ({mac_en, busy, done} !== 3'b110) begin
        n_fail++;
        $display("FAIL %s ctrl k=%0d: got mac_en/busy/done=%b want 110", nm, k, {mac_en, busy, done});
      end
      if (k == wr_k) begin WrEn = 1'b1; Waddr = AW'(1); Wdata = '1; end
      if (k == st_k) start = 1'b1;
      @(negedge clk);
      WrEn = 1'b0; Wdata = '0; start = 1'b0;
    end
    n_checks++;
    if ({mac_en, busy, done} !== 3'b001 || Aout !== '0) begin
      n_fail++;
      $display("FAIL %s end: got mac_en/busy/done=%b aout=%h want 001 aout=0", nm, {mac_en, busy, done}, Aout);
    end
    if (!b2b) begin
      @(negedge clk);
      n_checks++;
      if ({mac_en, busy, done} !== 3'b000) begin
        n_fail++;
        $display("FAIL %s after_done: got mac_en/busy/done=%b want 000", nm, {mac_en, busy, done});
      end
    end
  endtask

  task automatic test_reset();
    clear_model();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({Aout, mac_en, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: got aout=%h ctrl=%b want all 0", Aout, {mac_en, busy, done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({Aout, mac_en, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_released: got aout=%h ctrl=%b want all 0", Aout, {mac_en, busy, done});
    end
    run_pass("zero_tile", -1, -1, 1'b0);
  endtask

  task automatic test_stream();
    for (int r = 0; r < DIM; r++) begin
      logic [W-1:0] d;
      for (int c = 0; c < DIM; c++) d[c*BITS_AB +: BITS_AB] = BITS_AB'(10 * r + c);
      write_row(r, d);
    end
    run_pass("stream", -1, -1, 1'b0);
    n_checks++;
    if (cap[0] !== 32'h0000_0000) begin
      n_fail++; $display("FAIL stream_k0: got %h want 00000000", cap[0]);
    end
    n_checks++;
    if (cap[3] !== 32'h1E15_0C03) begin
      n_fail++; $display("FAIL stream_k3: got %h want 1e150c03", cap[3]);
    end
    n_checks++;
    if (cap[6] !== 32'h2100_0000) begin
      n_fail++; $display("FAIL stream_k6: got %h want 21000000", cap[6]);
    end
    for (int k = 7; k <= 9; k++) begin
      n_checks++;
      if (cap[k] !== 32'h0) begin
        n_fail++; $display("FAIL stream_tail k=%0d: got %h want 00000000", k, cap[k]);
      end
    end
  endtask

  task automatic test_signed();
    write_row(0, 32'h0000_7F80);
    run_pass("signed", -1, -1, 1'b0);
    n_checks++;
    if ($signed(cap[0][7:0]) !== -8'sd128) begin
      n_fail++; $display("FAIL signed_neg: got %0d want -128", $signed(cap[0][7:0]));
    end
    n_checks++;
    if ($signed(cap[1][7:0]) !== 8'sd127) begin
      n_fail++; $display("FAIL signed_pos: got %0d want 127", $signed(cap[1][7:0]));
    end
  endtask

  task automatic test_illegal();
    run_pass("illegal", 3, 5, 1'b0);
    run_pass("illegal_after", -1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    WrEn = 1'b1; start = 1'b1; Waddr = AW'(2); Wdata = 32'h0A0B_0C0D;
    @(negedge clk);
    WrEn = 1'b0; start = 1'b0; Wdata = '0;
    for (int c = 0; c < DIM; c++) tmem[2][c] = BITS_AB'(32'h0A0B_0C0D >> (8 * c));
    for (int n = 0; n < 2; n++) begin
      n_checks++;
      if ({mac_en, busy} !== 2'b00) begin
        n_fail++; $display("FAIL wr_start_same n=%0d: got mac_en/busy=%b want 00", n, {mac_en, busy});
      end
      @(negedge clk);
    end
    run_pass("b2b_first", -1, -1, 1'b1);
    run_pass("b2b_second", -1, -1, 1'b0);
  endtask

  task automatic test_reset_mid_pass();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (Aout !== exp_aout(5) || mac_en !== 1'b1) begin
      n_fail++; $display("FAIL mid_pass_k5: got %h en=%b want %h en=1", Aout, mac_en, exp_aout(5));
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({Aout, mac_en, busy, done} !== '0) begin
      n_fail++; $display("FAIL async_abort: got aout=%h ctrl=%b want all 0", Aout, {mac_en, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      n_checks++;
      if ({mac_en, busy, done} !== 3'b000) begin
        n_fail++; $display("FAIL no_done_after_abort n=%0d: got %b want 000", n, {mac_en, busy, done});
      end
    end
    run_pass("zeroed_after_abort", -1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_signed();
    test_illegal();
    test_back_to_back();
    test_reset_mid_pass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
